// File: rtl/seg_pkg.sv
// seg_pkg
// Shared constants for the seven-segment scan decoder:
//   - active-low segment patterns for the digits 0..9 (bit6=a ... bit0=g)
//   - active-low anode patterns for the four digit positions and for blanking
//   - state type of the frame-assembly FSM
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] AN_DIGIT0 = 4'b1110;
    localparam logic [3:0] AN_DIGIT1 = 4'b1101;
    localparam logic [3:0] AN_DIGIT2 = 4'b1011;
    localparam logic [3:0] AN_DIGIT3 = 4'b0111;
    localparam logic [3:0] AN_BLANK  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode
// Purely combinational seven-segment pattern to BCD digit decoder.
// Ports:
//   pattern_i  [6:0]  active-low segment pattern, bit6=a ... bit0=g
//   digit_o    [3:0]  decoded digit 0..9 (0 when the pattern is illegal)
//   legal_o           1 when pattern_i is one of the ten digit patterns
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] digit_o,
    output logic       legal_o
);

    always_comb begin
        digit_o = 4'd0;
        legal_o = 1'b1;
        case (pattern_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Recovers the 4-digit decimal value shown on a multiplexed, active-low
// seven-segment display by watching its anode and cathode lines.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   an   [3:0] anodes, active-low (1110 = ones digit ... 0111 = thousands)
//   seg  [6:0] cathodes, active-low, bit6=a ... bit0=g
//   number [13:0] binary value of the last complete frame, 0..9999
//   valid      one-cycle pulse when number is updated
//   digit_err  one-cycle pulse on an illegal anode or segment pattern
// Parameter STABLE_CYCLES (2..255): identical samples needed to accept a phase.
// Optional build macro SEG_SCAN_CHANGE_ONLY_EN: valid pulses only when the
// converted value differs from number, or on the first frame after reset.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for an accepted digit0 to start a frame
// COLLECT  | digits 0..exp-1 stored, waiting for digit exp
// CONVERT  | four-step BCD to binary multiply-accumulate, accepts ignored
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [13:0] number,
    output logic        valid,
    output logic        digit_err
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [7:0]  stable_q, stable_d;
    logic        accept_q, accept_d;

    state_t      state_q, state_d;
    logic [1:0]  exp_q, exp_d;
    logic [3:0][3:0] digits_q, digits_d;
    logic [1:0]  step_q, step_d;
    logic [13:0] acc_q, acc_d;
    logic [13:0] number_q, number_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        an_blank, an_bad;
    logic [1:0]  an_idx;
    logic [3:0]  seg_digit;
    logic        seg_legal;
    logic        take;
    logic [1:0]  conv_idx;
    logic [13:0] mac;

    // Comparing the incoming lines with the sample register is the same as
    // comparing the next sample with the current one, so stable_q always
    // describes the value currently held in an_q/seg_q.
    always_comb begin
        stable_d = stable_q;
        if ({an, seg} != {an_q, seg_q}) begin
            stable_d = 8'd0;
        end else if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + 8'd1;
        end
        accept_d = (stable_d == STABLE_MAX) && (stable_q != STABLE_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q     <= '1;
            seg_q    <= '1;
            stable_q <= 8'd0;
            accept_q <= 1'b0;
        end else begin
            an_q     <= an;
            seg_q    <= seg;
            stable_q <= stable_d;
            accept_q <= accept_d;
        end
    end

    always_comb begin
        an_blank = 1'b0;
        an_bad   = 1'b0;
        an_idx   = 2'd0;
        case (an_q)
            AN_DIGIT0: an_idx = 2'd0;
            AN_DIGIT1: an_idx = 2'd1;
            AN_DIGIT2: an_idx = 2'd2;
            AN_DIGIT3: an_idx = 2'd3;
            AN_BLANK:  an_blank = 1'b1;
            default:   an_bad = 1'b1;
        endcase
    end

    seg_pattern_decode u_decode (
        .pattern_i (seg_q),
        .digit_o   (seg_digit),
        .legal_o   (seg_legal)
    );

`ifdef SEG_SCAN_CHANGE_ONLY_EN
    logic first_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            first_q <= 1'b1;
        end else if (state_q == ST_CONVERT && step_q == 2'd3) begin
            first_q <= 1'b0;
        end
    end
`endif

    assign take = accept_q && !an_blank;

    // acc is cleared on entry to CONVERT, so step 0 (acc*10 + d3) yields d3
    // and every step can share the same multiply-accumulate.
    assign conv_idx = 2'd3 - step_q;
    assign mac      = (acc_q * 14'd10) + {10'd0, digits_q[conv_idx]};

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        digits_d = digits_q;
        step_d   = step_q;
        acc_d    = acc_q;
        number_d = number_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (an_bad || !seg_legal) begin
                        err_d = 1'b1;
                    end else if (an_idx == 2'd0) begin
                        digits_d[0] = seg_digit;
                        exp_d       = 2'd1;
                        state_d     = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (take) begin
                    if (an_bad || !seg_legal) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (an_idx == exp_q) begin
                        digits_d[an_idx] = seg_digit;
                        exp_d            = exp_q + 2'd1;
                        if (an_idx == 2'd3) begin
                            state_d = ST_CONVERT;
                            step_d  = 2'd0;
                            acc_d   = 14'd0;
                        end
                    end else if (an_idx == 2'd0) begin
                        digits_d[0] = seg_digit;
                        exp_d       = 2'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CONVERT: begin
                acc_d  = mac;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    number_d = mac;
                    state_d  = ST_IDLE;
`ifdef SEG_SCAN_CHANGE_ONLY_EN
                    valid_d  = first_q || (mac != number_q);
`else
                    valid_d  = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            exp_q    <= 2'd0;
            digits_q <= '0;
            step_q   <= 2'd0;
            acc_q    <= 14'd0;
            number_q <= 14'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            digits_q <= digits_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            number_q <= number_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign number    = number_q;
    assign valid     = valid_q;
    assign digit_err = err_q;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit phase is accepted (legal range 2..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 an  input  4  multiplexed anodes, active-low: 1110=digit0 (ones), 1101=digit1, 1011=digit2, 0111=digit3.
REQ-005 seg  input  7  segment cathodes, active-low, bit6=a ... bit0=g.
REQ-006 number  output  14  binary value of the last complete frame, 0..9999.
REQ-007 valid  output  1  one-cycle pulse when number is updated.
REQ-008 digit_err  output  1  one-cycle pulse on an illegal anode or segment pattern.

Function
REQ-009 an and seg SHALL be registered into a sample register each cycle; all decoding uses the sampled value.
REQ-010 An 8-bit stable counter SHALL clear when the sample differs from the previous sample, else increment, saturating at STABLE_CYCLES.
REQ-011 An accept strobe SHALL fire for exactly one cycle, in the cycle the counter reaches STABLE_CYCLES; it does not fire again until the sample changes.
REQ-012 an=1111 at accept is blanking: ignored, no error, FSM unchanged.
REQ-013 an with more than one bit low at accept SHALL pulse digit_err and return the FSM to IDLE.
REQ-014 Segment decode: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; any other pattern at accept pulses digit_err and returns the FSM to IDLE.
REQ-015 FSM states: IDLE, COLLECT, CONVERT.
REQ-016 IDLE: an accepted digit0 stores its value, sets expected index 1, and moves to COLLECT; other digits are ignored.
REQ-017 COLLECT: an accepted digit equal to the expected index stores its value and increments the index; digit3 moves to CONVERT.
REQ-018 COLLECT, out-of-order digit: if it is digit0, restart the frame with it and stay in COLLECT; otherwise go to IDLE.
REQ-019 CONVERT SHALL take exactly 4 cycles, using a 14-bit accumulator: acc=d3, then acc=acc*10+d2, then acc*10+d1, then acc*10+d0.
REQ-020 Latency: digit3 accepted at edge N; number loaded and valid=1 at edge N+4; valid=0 at edge N+5; FSM returns to IDLE at edge N+4.
REQ-021 Accept strobes arriving during CONVERT SHALL be ignored, including errors.
REQ-022 number SHALL hold its value between updates.

Reset
REQ-023 Reset SHALL set number=0, valid=0, digit_err=0, FSM=IDLE, stable counter=0, sample register=all ones, and stored digits=0.
REQ-024 Reset asserted mid-frame or during CONVERT SHALL abort the frame, with no valid pulse produced for that frame.

Configuration
REQ-025 With SEG_SCAN_CHANGE_ONLY_EN defined, valid SHALL pulse only when the converted value differs from number, or for the first frame after reset; number is still loaded.
REQ-026 Without SEG_SCAN_CHANGE_ONLY_EN, valid SHALL pulse at every completed frame.

Structure
REQ-027 Package seg_pkg SHALL hold the ten segment-pattern constants, the four anode constants, the blank constant, and the FSM state typedef.
REQ-028 Segment decoding SHALL be a combinational sub-module seg_pattern_decode: 7-bit pattern to a 4-bit digit plus a legal flag.

Verification
REQ-029 Scan 1234, each phase held 10 cycles, STABLE_CYCLES=4 -> one valid pulse with number=1234, exactly 4 cycles after digit3 accept.
REQ-030 2-cycle glitch on seg (digit1 pattern shown as 8) mid-phase during a 5678 scan -> number=5678, no digit_err.
REQ-031 seg=1111110 held on the digit1 phase -> one digit_err pulse, no valid that frame; next clean 0042 frame -> number=42.
REQ-032 Phases digit0, digit2, then a clean 0..3 scan of 9999 -> exactly one valid, number=9999.
REQ-033 Reset for 1 cycle during CONVERT -> number=0 and valid=0 next cycle, no valid pulse for the aborted frame.
REQ-034 SEG_SCAN_CHANGE_ONLY_EN defined, three identical 0000 frames after reset -> exactly one valid, number=0; undefined -> three valid pulses.
